// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD <-> binary converters.
// Optional digit-error reporting is enabled by defining BCD2BIN_ERR_EN.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } bcd_state_e;

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Input and output valid/ready channels of the BCD-to-binary converter.
// err_o is present only when BCD2BIN_ERR_EN is defined.
interface bcd2bin_seq_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);

  logic                          in_valid;
  logic                          in_ready;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_i;
  logic                          out_valid;
  logic                          out_ready;
  logic [BIN_W-1:0]              bin_o;
`ifdef BCD2BIN_ERR_EN
  logic                          err_o;
`endif

  modport master (
    output in_valid,
    output bcd_i,
    output out_ready,
`ifdef BCD2BIN_ERR_EN
    input  err_o,
`endif
    input  in_ready,
    input  out_valid,
    input  bin_o
  );

  modport slave (
    input  in_valid,
    input  bcd_i,
    input  out_ready,
`ifdef BCD2BIN_ERR_EN
    output err_o,
`endif
    output in_ready,
    output out_valid,
    output bin_o
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble nibble corrector: digits >= 8 drop by 3.
// Purely combinational, one instance per BCD digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  assign d_o = (d_i >= BCD_ADJ_THRESH) ? d_i - BCD_ADJ_SUB : d_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double dabble).
// Define BCD2BIN_ERR_EN to flag non-BCD input digits on err_o.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
)(
  input logic          clk,
  input logic          rst_n,
  bcd2bin_seq_if.slave bus
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CAT_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  bcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BIN_W-1:0] bin_q, bin_d;

  logic [CAT_W-1:0] cat_sh;
  logic [BCD_W-1:0] bcd_sh;
  logic [BCD_W-1:0] bcd_adj;
  logic [BIN_W-1:0] bin_sh;

  assign cat_sh = {bcd_q, bin_q} >> 1;
  assign bcd_sh = cat_sh[CAT_W-1:BIN_W];
  assign bin_sh = cat_sh[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_sh[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD2BIN_ERR_EN
  logic err_q, err_d;
  logic bad_in;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_i[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT)
        bad_in = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
`ifdef BCD2BIN_ERR_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          bcd_d   = bus.bcd_i;
          bin_d   = '0;
          cnt_d   = '0;
`ifdef BCD2BIN_ERR_EN
          err_d   = bad_in;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = bin_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST)
          state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
`ifdef BCD2BIN_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
`ifdef BCD2BIN_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);

  // Result is only exposed in DONE so the shifting value never leaks out.
`ifdef BCD2BIN_ERR_EN
  assign bus.bin_o = (bus.out_valid && !err_q) ? bin_q : '0;
  assign bus.err_o = err_q;
`else
  assign bus.bin_o = bus.out_valid ? bin_q : '0;
`endif

endmodule
